// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC, with stall, redirect flush and halt handling.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] iaddr,
    input  logic [15:0] idata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
    state_t      state;
    logic [15:0] pc;
    assign iaddr = pc;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (state == HALT) begin
            instr_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc & 16'hFFFE;
            instr_valid <= 1'b0;
            state       <= FLUSH;
        end else if (!(state == RUN && stall)) begin
            // Stall only matters in RUN; BOOT and FLUSH hold no valid word to protect
            instr       <= idata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
            if (idata == HALT_WORD) begin
                halted <= 1'b1;
                state  <= HALT;
            end else begin
                pc    <= pc + 16'd2;
                state <= RUN;
            end
        end
    end
endmodule
